uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

UART 8N1 transmitter with a 16-entry byte FIFO, the return path of the serial link whose receive side feeds the image buffer. It accepts bytes from the edge-detection pipeline (processed pixels, status bytes) at fabric rate and serializes them on `tx` at a fixed baud derived from the 50 MHz `clk`. Frames go out back-to-back while the FIFO holds data.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 434: clk cycles per serial bit (50 MHz / 115200); legal range 2..65535.
- `DEPTH_LOG2`, default 4: FIFO depth is 2^DEPTH_LOG2 entries (16).

Ports:
- `clk`  in  1  system clock, 50 MHz; all logic on the rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `wr_en`  in  1  write strobe; a byte is accepted on any edge where `wr_en`=1 and `full`=0.
- `din`  in  8  byte to transmit, sampled with `wr_en`.
- `full`  out  1  FIFO holds 2^DEPTH_LOG2 bytes; writes are ignored.
- `level`  out  DEPTH_LOG2+1  bytes in the FIFO, 0..16 (excludes the byte being shifted).
- `busy`  out  1  high while a frame is on the line (START, DATA or STOP).
- `tx`  out  1  serial line; idles high.

## Operation
- FIFO: circular buffer with DEPTH_LOG2-bit read/write pointers that wrap modulo depth. `level` tracks occupancy; `full` = (`level`==16). Write and pop in the same cycle leave `level` unchanged, and both take effect. A write while `full`=1 is dropped, even if a pop occurs that cycle. A pop never occurs with `level`=0.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `tx`=1, `busy`=0. If `level`!=0, pop the head byte into the shift register, clear the bit counter, load baud counter, and go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: `tx` = shift_reg[0]. The register shifts right every CLKS_PER_BIT cycles. After 8 bits (LSB first), go to STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. At the end, if `level`!=0, pop the next byte and go directly to START (no idle gap); otherwise go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1, wraps, and resets on every state entry. Bit boundaries therefore never drift.
- `tx` is driven from a register (glitch-free). `busy` is registered and high in START, DATA and STOP.
- Reset values: FSM=IDLE, `tx`=1, `busy`=0, `level`=0, `full`=0, pointers=0, counters=0. FIFO RAM contents are don't-care. Reset mid-frame aborts the frame: `tx` is 1 on the edge after `rst` is sampled, and queued bytes are discarded.

## Timing
- Write on edge N into an empty FIFO with the FSM in IDLE: `level`=1 after edge N. The pop occurs at edge N+1, so `level` returns to 0 and `busy`=1 and `tx`=0 (start bit) after edge N+1.
- Each bit lasts exactly CLKS_PER_BIT cycles. A frame is 10·CLKS_PER_BIT cycles.
- Back-to-back frames: the next start bit begins on the cycle immediately after the last stop-bit cycle.
- `full` and `level` update on the edge that accepts a write or performs a pop. There is no combinational path from `wr_en` to `full`.
- Throughput is one byte per 10·CLKS_PER_BIT cycles.

## Test plan
All scenarios use CLKS_PER_BIT=4.
- Reset: hold `rst` for 3 cycles -> `tx`=1, `busy`=0, `level`=0, `full`=0. With no writes, `tx` stays 1 for 100 cycles.
- Single byte: write 0x55 -> two edges later `tx` carries 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop), each bit exactly 4 cycles. `busy` is high for 40 cycles, then `tx`=1 and `busy`=0.
- Back-to-back: write 0xA5, 0x3C, 0xFF on consecutive cycles -> three frames totalling 120 cycles with no idle cycle between stop and start. Decoded bytes are 0xA5, 0x3C, 0xFF in order.
- Full/overflow: write 18 bytes 0x00..0x11 on consecutive cycles -> byte 0x00 is popped at once. `full`=1 after the 17th accepted write attempt, the last write (0x11) is dropped, and the line carries 0x00..0x10 in order.
- Simultaneous write/pop: with `level`=3, write on the exact cycle a stop bit ends -> `level` stays 3 and the written byte is transmitted fourth.
- Reset mid-frame: assert `rst` during data bit 3 of 0x0F with 2 bytes queued -> `tx`=1, `level`=0 on the next edge. After release, nothing is transmitted until a new write.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter fed by a circular byte FIFO; frames go out back-to-back
// while bytes are queued, with tx and busy driven straight from registers.
module uart_tx_fifo #(
   parameter int CLKS_PER_BIT = 434,
   parameter int DEPTH_LOG2   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [7:0]            din,
   output logic                  full,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  busy,
   output logic                  tx
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   localparam logic [15:0]           BAUD_LAST  = 16'(CLKS_PER_BIT - 1);
   localparam logic [DEPTH_LOG2:0]   LEVEL_ZERO = {(DEPTH_LOG2+1){1'b0}};
   localparam logic [DEPTH_LOG2:0]   LEVEL_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
   localparam logic [DEPTH_LOG2:0]   LEVEL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [DEPTH_LOG2-1:0] PTR_ZERO   = {DEPTH_LOG2{1'b0}};
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

   logic [7:0]            mem_r [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_r;
   logic [DEPTH_LOG2-1:0] rd_ptr_r;
   logic [DEPTH_LOG2:0]   level_r;
   logic [DEPTH_LOG2:0]   level_next_s;
   logic                  full_r;
   logic [1:0]            state_r;
   logic [15:0]           baud_r;
   logic [2:0]            bit_cnt_r;
   logic [7:0]            shift_r;
   logic                  tx_r;
   logic                  busy_r;
   logic                  baud_end_s;
   logic                  push_s;
   logic                  pop_s;

   assign baud_end_s = (baud_r == BAUD_LAST);
   // A write while full is dropped even when a pop frees a slot this cycle.
   assign push_s     = wr_en & ~full_r;

   // Pop request: leaving IDLE, or chaining the next frame at the end of STOP.
   always_comb begin
      pop_s = 1'b0;
      case (state_r)
         ST_IDLE: pop_s = (level_r != LEVEL_ZERO);
         ST_STOP: pop_s = baud_end_s && (level_r != LEVEL_ZERO);
         default: pop_s = 1'b0;
      endcase
   end

   // Next FIFO occupancy from this cycle's push and pop.
   always_comb begin
      level_next_s = level_r;
      if (push_s && !pop_s) begin
         level_next_s = level_r + LEVEL_ONE;
      end else if (!push_s && pop_s) begin
         level_next_s = level_r - LEVEL_ONE;
      end else begin
         level_next_s = level_r;
      end
   end

   // FIFO storage; contents need no reset.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= din;
      end
   end

   // FIFO pointers, occupancy and full flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= PTR_ZERO;
         rd_ptr_r <= PTR_ZERO;
         level_r  <= LEVEL_ZERO;
         full_r   <= 1'b0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         level_r <= level_next_s;
         full_r  <= (level_next_s == LEVEL_FULL);
      end
   end

   // Serializer FSM; the baud counter restarts on every state entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         baud_r    <= 16'd0;
         bit_cnt_r <= 3'd0;
         shift_r   <= 8'd0;
         tx_r      <= 1'b1;
         busy_r    <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               baud_r    <= 16'd0;
               bit_cnt_r <= 3'd0;
               if (pop_s) begin
                  shift_r <= mem_r[rd_ptr_r];
                  state_r <= ST_START;
                  tx_r    <= 1'b0;
                  busy_r  <= 1'b1;
               end else begin
                  tx_r    <= 1'b1;
                  busy_r  <= 1'b0;
               end
            end
            ST_START: begin
               if (baud_end_s) begin
                  baud_r  <= 16'd0;
                  state_r <= ST_DATA;
                  tx_r    <= shift_r[0];
               end else begin
                  baud_r  <= baud_r + 16'd1;
               end
            end
            ST_DATA: begin
               if (baud_end_s) begin
                  baud_r <= 16'd0;
                  if (bit_cnt_r == 3'd7) begin
                     state_r <= ST_STOP;
                     tx_r    <= 1'b1;
                  end else begin
                     shift_r   <= {1'b0, shift_r[7:1]};
                     tx_r      <= shift_r[1];
                     bit_cnt_r <= bit_cnt_r + 3'd1;
                  end
               end else begin
                  baud_r <= baud_r + 16'd1;
               end
            end
            ST_STOP: begin
               if (baud_end_s) begin
                  baud_r    <= 16'd0;
                  bit_cnt_r <= 3'd0;
                  if (pop_s) begin
                     shift_r <= mem_r[rd_ptr_r];
                     state_r <= ST_START;
                     tx_r    <= 1'b0;
                  end else begin
                     state_r <= ST_IDLE;
                     tx_r    <= 1'b1;
                     busy_r  <= 1'b0;
                  end
               end else begin
                  baud_r <= baud_r + 16'd1;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               baud_r  <= 16'd0;
               tx_r    <= 1'b1;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign full  = full_r;
   assign level = level_r;
   assign busy  = busy_r;
   assign tx    = tx_r;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: accepted bytes are queued on write and each
// frame seen on tx is compared cycle-by-cycle against the expected 8N1 waveform.
module tb_uart_tx_fifo;

   localparam int CPB = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_en = 1'b0;
   logic [7:0] din = 8'h00;
   logic       full;
   logic [4:0] level;
   logic       busy;
   logic       tx;

   int errors = 0;
   int checks = 0;
   logic [7:0] sb[$];
   int starts[$];
   int cycle = 0;
   bit in_frame = 1'b0;
   int fcyc = 0;
   logic [39:0] wave;
   logic busy_ok;
   logic [7:0] exp_b;

   uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH_LOG2(4)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .din(din),
      .full(full), .level(level), .busy(busy), .tx(tx)
   );

   always #5 clk = ~clk;

   task automatic check(string tag, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [39:0] frame_wave(logic [7:0] b);
      logic [9:0]  f;
      logic [39:0] w;
      f = {1'b1, b, 1'b0};
      for (int i = 0; i < 40; i++) w[i] = f[i / CPB];
      return w;
   endfunction

   // Line monitor: capture each frame from its start bit and compare to the scoreboard.
   initial forever begin
      @(negedge clk);
      cycle++;
      if (rst) begin
         in_frame = 1'b0;
      end else if (!in_frame && tx === 1'b0) begin
         in_frame = 1'b1;
         fcyc     = 0;
         busy_ok  = 1'b1;
         starts.push_back(cycle);
         check("frame_expected", sb.size() != 0, 1'b1);
         if (sb.size() != 0) exp_b = sb.pop_front();
         else exp_b = 8'h00;
      end
      if (in_frame) begin
         wave[fcyc] = tx;
         busy_ok    = busy_ok & busy;
         fcyc++;
         if (fcyc == 40) begin
            check("frame_wave", wave, frame_wave(exp_b));
            check("frame_busy", busy_ok, 1'b1);
            in_frame = 1'b0;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] d, input bit accept);
      wr_en = 1'b1;
      din   = d;
      if (accept) sb.push_back(d);
      step();
      wr_en = 1'b0;
   endtask

   task automatic wait_drain(input int max);
      int n = 0;
      while ((sb.size() != 0 || in_frame || busy) && n < max) begin
         step();
         n++;
      end
      check("drain_in_time", n < max, 1'b1);
   endtask

   task automatic idle_window(input string tag);
      logic ok = 1'b1;
      for (int i = 0; i < 100; i++) begin
         step();
         if (tx !== 1'b1 || busy !== 1'b0) ok = 1'b0;
      end
      check(tag, ok, 1'b1);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset and idle line
      rst = 1'b1;
      repeat (3) step();
      check("rst_tx", tx, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_level", level, 5'd0);
      check("rst_full", full, 1'b0);
      rst = 1'b0;
      idle_window("idle_after_reset");

      // Single byte: first-frame latency and frame length
      wr(8'h55, 1'b1);
      check("single_level_n", level, 5'd1);
      check("single_busy_n", busy, 1'b0);
      check("single_tx_n", tx, 1'b1);
      step();
      check("single_level_n1", level, 5'd0);
      check("single_busy_n1", busy, 1'b1);
      check("single_tx_n1", tx, 1'b0);
      repeat (39) step();
      check("single_busy_last", busy, 1'b1);
      step();
      check("single_busy_end", busy, 1'b0);
      check("single_tx_end", tx, 1'b1);
      wait_drain(100);

      // Back-to-back frames with no idle gap
      starts.delete();
      wr(8'hA5, 1'b1);
      wr(8'h3C, 1'b1);
      wr(8'hFF, 1'b1);
      wait_drain(300);
      check("b2b_frames", starts.size(), 3);
      if (starts.size() == 3) begin
         check("b2b_gap1", starts[1] - starts[0], 40);
         check("b2b_gap2", starts[2] - starts[1], 40);
      end

      // Overflow: 18 writes, the last one dropped
      for (int i = 0; i < 18; i++) begin
         wr(8'(i), i < 17);
         if (i == 15) begin
            check("ovf_level15", level, 5'd15);
            check("ovf_full15", full, 1'b0);
         end
         if (i >= 16) begin
            check("ovf_level16", level, 5'd16);
            check("ovf_full16", full, 1'b1);
         end
      end
      wait_drain(1000);
      check("ovf_empty", level, 5'd0);

      // Write on the exact edge a stop bit ends and the next byte is popped
      wr(8'h10, 1'b1);
      wr(8'h11, 1'b1);
      wr(8'h12, 1'b1);
      wr(8'h13, 1'b1);
      repeat (37) step();
      check("simul_level_before", level, 5'd3);
      wr(8'h14, 1'b1);
      check("simul_level_after", level, 5'd3);
      check("simul_busy", busy, 1'b1);
      check("simul_tx_start", tx, 1'b0);
      wait_drain(400);

      // Reset during data bit 3 of 0x0F with two bytes queued
      wr(8'h0F, 1'b1);
      wr(8'h21, 1'b1);
      wr(8'h22, 1'b1);
      repeat (17) step();
      check("mid_level_before", level, 5'd2);
      rst = 1'b1;
      sb.delete();
      step();
      check("mid_tx", tx, 1'b1);
      check("mid_level", level, 5'd0);
      check("mid_busy", busy, 1'b0);
      check("mid_full", full, 1'b0);
      rst = 1'b0;
      idle_window("idle_after_abort");
      wr(8'hC3, 1'b1);
      wait_drain(200);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
